radix_serial_multiplier: RTL and testbench
==========================================

Name: radix_serial_multiplier

Overview:
- Next-generation serial shift-add multiplier, parametrised in operand width and in multiplier bits retired per cycle (radix).
- Adds per-transaction signed/unsigned mode and full valid/ready handshakes on both the operand and product sides.
- Sits as a low-area arithmetic unit in datapaths that can tolerate multi-cycle latency.

Parameters:
- WIDTH, 8: operand width in bits; product is 2*WIDTH.
- RADIX_BITS, 1: multiplier bits consumed per compute cycle; legal values are 1, 2 or 4, and RADIX_BITS must divide WIDTH (elaboration-time assertion).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- multiplier_valid  in  1  operands present.
- multiplier_ready  out  1  block can accept operands.
- signed_mode  in  1  1 = two's-complement operands; sampled with the operands.
- multiplier1  in  WIDTH  multiplicand.
- multiplier2  in  WIDTH  multiplier.
- product_valid  out  1  product present.
- product_ready  in  1  consumer accepts the product.
- product  out  2*WIDTH  result; signed or unsigned per the captured mode.

Behaviour:
- Definitions: N = WIDTH/RADIX_BITS compute cycles. State machine states are IDLE, CALC and DONE.
- Reset: asynchronous assert forces state to IDLE, multiplier_ready=1, product_valid=0, product=0, and clears all internal registers.
- Reset mid-operation aborts the operation with no output.
- IDLE:
  - multiplier_ready=1.
  - On an edge with multiplier_valid=1: capture mode and operand magnitudes (abs value when signed_mode=1), capture result sign = sign1 XOR sign2, clear the accumulator, and go to CALC.
- CALC:
  - multiplier_ready=0.
  - Each edge adds (multiplicand magnitude × low RADIX_BITS digit of the multiplier shift register) into the accumulator at the current digit offset, then shifts the multiplier right by RADIX_BITS.
  - A digit counter runs 0..N-1. On the edge retiring digit N-1: load product (two's-complement negated if the result sign is 1) and go to DONE.
- DONE:
  - product_valid=1 and product is stable.
  - On an edge with product_ready=1: go to IDLE and clear product_valid. The product register holds its value.
  - multiplier_ready stays 0 in DONE, so there is no accept/complete overlap.
- Latency: the operand-accept edge is edge 0; product_valid is high after edge N. Throughput is one result per N+2 cycles when product_ready is tied high.
- Width rules:
  - Magnitudes are WIDTH bits unsigned; -2^(WIDTH-1) has magnitude 2^(WIDTH-1), which fits.
  - The accumulator is 2*WIDTH bits and never overflows.
  - Signed product range (-2^(W-1))^2 = 2^(2W-2) fits in 2*WIDTH signed.
- Zero operands follow the normal path. Without the optional feature, the zero-operand result is exactly 0 after N cycles, never -0 artifacts.
- Inputs changing while multiplier_ready=0 are ignored.
- product_ready asserted outside DONE has no effect.

Optional Feature:
- Macro: SERIAL_MULT_EARLY_TERM_EN.
- Defined:
  - In CALC, when the remaining multiplier shift register is all zeros, the current edge finalises the product and enters DONE early.
  - A multiplier magnitude of 0 completes at edge 1; 0x01 with RADIX_BITS=1 completes at edge 1.
  - Results are identical to the non-early path.
- Undefined: always exactly N compute cycles; no zero-detect logic.

Decomposition:
- Package serial_mult_pkg holds:
  - state enum state_t (IDLE, CALC, DONE);
  - localparam-style function digits(WIDTH, RADIX_BITS);
  - function abs_mag(value, signed_mode).
- One sub-module, radix_pp_gen: combinational multiplicand × RADIX_BITS-digit partial product, WIDTH+RADIX_BITS wide.

Test Plan (WIDTH=8, RADIX_BITS=2, so N=4, unless noted):
- Unsigned 200×250, product_ready=1: product_valid high after edge 4; product=50000 (0xC350); multiplier_ready returns 1 one cycle later.
- Signed -128×-128: product=16384 (0x4000). Signed -7×5: product=0xFFDD (-35). Signed 127×-1: product=0xFF81.
- Backpressure: hold product_ready=0 for 10 cycles after 3×4. Product must stay 12 with product_valid held high and multiplier_ready=0; a new operand offered meanwhile is not accepted.
- Reset mid-CALC: pulse rst_n low at edge 2 of 9×9. Outputs return to reset values immediately; the next operation 15×17=255 completes correctly.
- Sweep all 3 RADIX_BITS values × both modes with 1000 random operand pairs each, including 0, 1, max and min. Every result matches the reference product; cycle count equals N exactly (or ≤N with SERIAL_MULT_EARLY_TERM_EN).
- SERIAL_MULT_EARLY_TERM_EN defined, RADIX_BITS=1: 0x55×0x03 gives product=0xFF, DONE at edge 2. 0x55×0x00 gives product=0, DONE at edge 1.

Source files
------------

// File: rtl/radix_serial_multiplier_pkg.sv
// Shared types and helpers for the radix serial multiplier.
package serial_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Widest operand abs_mag can handle; callers sign- or zero-extend to this width.
    localparam int unsigned MagMaxW = 64;

    function automatic int unsigned digits(input int unsigned width,
                                           input int unsigned radix_bits);
        return width / radix_bits;
    endfunction

    function automatic logic [MagMaxW-1:0] abs_mag(input logic [MagMaxW-1:0] value,
                                                   input logic               signed_mode);
        return (signed_mode && value[MagMaxW-1]) ? -value : value;
    endfunction

endpackage

// File: rtl/radix_serial_multiplier_if.sv
// Operand/product handshake bundle for radix_serial_multiplier.
interface radix_serial_multiplier_if #(
    parameter int unsigned WIDTH = 8
);
    logic                 multiplier_valid;
    logic                 multiplier_ready;
    logic                 signed_mode;
    logic [WIDTH-1:0]     multiplier1;
    logic [WIDTH-1:0]     multiplier2;
    logic                 product_valid;
    logic                 product_ready;
    logic [2*WIDTH-1:0]   product;

    modport master (
        output multiplier_valid,
        output signed_mode,
        output multiplier1,
        output multiplier2,
        output product_ready,
        input  multiplier_ready,
        input  product_valid,
        input  product
    );

    modport slave (
        input  multiplier_valid,
        input  signed_mode,
        input  multiplier1,
        input  multiplier2,
        input  product_ready,
        output multiplier_ready,
        output product_valid,
        output product
    );

endinterface

// File: rtl/radix_serial_multiplier_pp_gen.sv
// Combinational multiplicand x RADIX_BITS-digit partial product.
module radix_pp_gen #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RADIX_BITS = 1
) (
    input  logic [WIDTH-1:0]            mcand_i,
    input  logic [RADIX_BITS-1:0]       digit_i,
    output logic [WIDTH+RADIX_BITS-1:0] pp_o
);
    localparam int unsigned PpW = WIDTH + RADIX_BITS;

    assign pp_o = PpW'(mcand_i) * PpW'(digit_i);

endmodule

// File: rtl/radix_serial_multiplier.sv
// Serial shift-add multiplier retiring RADIX_BITS multiplier bits per cycle.
// Define SERIAL_MULT_EARLY_TERM_EN to finish as soon as the remaining multiplier is zero.
module radix_serial_multiplier
    import serial_mult_pkg::*;
#(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned RADIX_BITS = 1
) (
    input logic                      clk,
    input logic                      rst_n,
    radix_serial_multiplier_if.slave bus_io
);
    localparam int unsigned N     = digits(WIDTH, RADIX_BITS);
    localparam int unsigned CntW  = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned PpW   = WIDTH + RADIX_BITS;
    localparam int unsigned ProdW = 2 * WIDTH;

    if (!(RADIX_BITS == 1 || RADIX_BITS == 2 || RADIX_BITS == 4)) begin : g_bad_radix
        $error("RADIX_BITS must be 1, 2 or 4");
    end
    if ((WIDTH % RADIX_BITS) != 0) begin : g_bad_split
        $error("RADIX_BITS must divide WIDTH");
    end
    if (WIDTH >= MagMaxW) begin : g_bad_width
        $error("WIDTH too large for abs_mag");
    end

    state_t           state_q, state_d;
    logic             neg_q, neg_d;
    logic [WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0] mplier_q, mplier_d;
    logic [ProdW-1:0] acc_q, acc_d;
    logic [ProdW-1:0] product_q, product_d;
    logic [CntW-1:0]  cnt_q, cnt_d;

    logic             sgn1, sgn2;
    logic [WIDTH-1:0] mag1, mag2;
    logic [WIDTH-1:0] mplier_shift;
    logic [PpW-1:0]   pp;
    logic [ProdW-1:0] acc_sum;
    logic             last_digit;

    assign sgn1 = bus_io.signed_mode & bus_io.multiplier1[WIDTH-1];
    assign sgn2 = bus_io.signed_mode & bus_io.multiplier2[WIDTH-1];
    assign mag1 = WIDTH'(abs_mag({{(MagMaxW-WIDTH){sgn1}}, bus_io.multiplier1},
                                 bus_io.signed_mode));
    assign mag2 = WIDTH'(abs_mag({{(MagMaxW-WIDTH){sgn2}}, bus_io.multiplier2},
                                 bus_io.signed_mode));

    radix_pp_gen #(
        .WIDTH      (WIDTH),
        .RADIX_BITS (RADIX_BITS)
    ) u_pp_gen (
        .mcand_i (mcand_q),
        .digit_i (mplier_q[RADIX_BITS-1:0]),
        .pp_o    (pp)
    );

    assign mplier_shift = mplier_q >> RADIX_BITS;
    assign acc_sum      = acc_q + (ProdW'(pp) << (RADIX_BITS * 32'(cnt_q)));

`ifdef SERIAL_MULT_EARLY_TERM_EN
    // Nothing left to add once the unconsumed multiplier bits are all zero.
    assign last_digit = (cnt_q == CntW'(N - 1)) || (mplier_shift == '0);
`else
    assign last_digit = (cnt_q == CntW'(N - 1));
`endif

    always_comb begin
        state_d   = state_q;
        neg_d     = neg_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        acc_d     = acc_q;
        cnt_d     = cnt_q;
        product_d = product_q;
        unique case (state_q)
            IDLE: begin
                if (bus_io.multiplier_valid) begin
                    neg_d    = sgn1 ^ sgn2;
                    mcand_d  = mag1;
                    mplier_d = mag2;
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = CALC;
                end
            end
            CALC: begin
                acc_d    = acc_sum;
                mplier_d = mplier_shift;
                cnt_d    = cnt_q + CntW'(1);
                if (last_digit) begin
                    product_d = neg_q ? -acc_sum : acc_sum;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (bus_io.product_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            neg_q     <= 1'b0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            neg_q     <= neg_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            acc_q     <= acc_d;
            cnt_q     <= cnt_d;
            product_q <= product_d;
        end
    end

    assign bus_io.multiplier_ready = (state_q == IDLE);
    assign bus_io.product_valid    = (state_q == DONE);
    assign bus_io.product          = product_q;

endmodule

// File: tb/tb_radix_serial_multiplier.sv
// Self-checking bench: three radix variants (1/2/4) at WIDTH=8 against an arithmetic model.
module tb_radix_serial_multiplier;

    logic        clk = 1'b0;
    logic        rst_n;
    int          sel;
    logic        tb_valid;
    logic        tb_mode;
    logic        tb_pready;
    logic [7:0]  tb_a;
    logic [7:0]  tb_b;
    logic        obs_ready;
    logic        obs_pv;
    logic [15:0] obs_prod;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    radix_serial_multiplier_if #(.WIDTH(8)) if1 ();
    radix_serial_multiplier_if #(.WIDTH(8)) if2 ();
    radix_serial_multiplier_if #(.WIDTH(8)) if4 ();

    assign if1.multiplier_valid = tb_valid && (sel == 1);
    assign if2.multiplier_valid = tb_valid && (sel == 2);
    assign if4.multiplier_valid = tb_valid && (sel == 4);
    assign if1.signed_mode = tb_mode;
    assign if2.signed_mode = tb_mode;
    assign if4.signed_mode = tb_mode;
    assign if1.multiplier1 = tb_a;
    assign if2.multiplier1 = tb_a;
    assign if4.multiplier1 = tb_a;
    assign if1.multiplier2 = tb_b;
    assign if2.multiplier2 = tb_b;
    assign if4.multiplier2 = tb_b;
    assign if1.product_ready = tb_pready;
    assign if2.product_ready = tb_pready;
    assign if4.product_ready = tb_pready;

    always_comb begin
        obs_ready = if2.multiplier_ready;
        obs_pv    = if2.product_valid;
        obs_prod  = if2.product;
        case (sel)
            1: begin
                obs_ready = if1.multiplier_ready;
                obs_pv    = if1.product_valid;
                obs_prod  = if1.product;
            end
            4: begin
                obs_ready = if4.multiplier_ready;
                obs_pv    = if4.product_valid;
                obs_prod  = if4.product;
            end
            default: ;
        endcase
    end

    radix_serial_multiplier #(.WIDTH(8), .RADIX_BITS(1)) u_dut1 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (if1)
    );
    radix_serial_multiplier #(.WIDTH(8), .RADIX_BITS(2)) u_dut2 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (if2)
    );
    radix_serial_multiplier #(.WIDTH(8), .RADIX_BITS(4)) u_dut4 (
        .clk    (clk),
        .rst_n  (rst_n),
        .bus_io (if4)
    );

    function automatic logic [15:0] ref_product(input logic mode, input logic [7:0] a,
                                                input logic [7:0] b);
        int ia;
        int ib;
        if (mode) begin
            ia = int'($signed(a));
            ib = int'($signed(b));
        end else begin
            ia = int'(a);
            ib = int'(b);
        end
        return 16'(ia * ib);
    endfunction

    // Edges from accept to product_valid.
    function automatic int ref_latency(input int radix, input logic mode, input logic [7:0] b);
`ifdef SERIAL_MULT_EARLY_TERM_EN
        int mag;
        int nbits;
        mag = (mode && b[7]) ? -int'($signed(b)) : int'(b);
        nbits = 0;
        while (mag > 0) begin
            nbits++;
            mag = mag / 2;
        end
        if (nbits == 0) return 1;
        return (nbits + radix - 1) / radix;
`else
        return 8 / radix;
`endif
    endfunction

    task automatic wait_ready();
        for (int i = 0; i < 40 && !obs_ready; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that raised product_valid.
    task automatic run_op(input logic mode, input logic [7:0] a, input logic [7:0] b,
                          output logic [15:0] prod, output int lat);
        wait_ready();
        tb_mode  = mode;
        tb_a     = a;
        tb_b     = b;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        lat = -1;
        for (int i = 1; i <= 40; i++) begin
            @(posedge clk);
            #1;
            if (obs_pv) begin
                lat = i;
                break;
            end
        end
        prod = obs_prod;
    endtask

    task automatic test_reset();
        int sels[3];
        sels = '{1, 2, 4};
        rst_n     = 1'b0;
        tb_valid  = 1'b0;
        tb_mode   = 1'b0;
        tb_pready = 1'b1;
        tb_a      = '0;
        tb_b      = '0;
        repeat (3) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            sel = sels[k];
            #1;
            n_checks++;
            if (obs_ready !== 1'b1 || obs_pv !== 1'b0 || obs_prod !== 16'h0) begin
                n_errors++;
                $display("FAIL reset_r%0d: ready=%b valid=%b product=%h, want ready=1 valid=0 product=0000",
                         sel, obs_ready, obs_pv, obs_prod);
            end
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_unsigned_basic();
        logic [15:0] p;
        int          lat;
        sel = 2;
        run_op(1'b0, 8'd200, 8'd250, p, lat);
        n_checks++;
        if (p !== 16'hC350) begin
            n_errors++;
            $display("FAIL unsigned_200x250: product=%h want c350", p);
        end
        n_checks++;
        if (lat !== ref_latency(2, 1'b0, 8'd250)) begin
            n_errors++;
            $display("FAIL unsigned_latency: got %0d want %0d", lat, ref_latency(2, 1'b0, 8'd250));
        end
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_ready !== 1'b1 || obs_pv !== 1'b0) begin
            n_errors++;
            $display("FAIL ready_return: ready=%b valid=%b want 1/0", obs_ready, obs_pv);
        end
    endtask

    task automatic test_signed();
        logic [7:0]  as[3];
        logic [7:0]  bs[3];
        logic [15:0] want[3];
        logic [15:0] p;
        int          lat;
        as   = '{8'h80, 8'hF9, 8'h7F};
        bs   = '{8'h80, 8'h05, 8'hFF};
        want = '{16'h4000, 16'hFFDD, 16'hFF81};
        sel = 2;
        for (int k = 0; k < 3; k++) begin
            run_op(1'b1, as[k], bs[k], p, lat);
            n_checks++;
            if (p !== want[k] || lat < 0) begin
                n_errors++;
                $display("FAIL signed_%0d: %h*%h product=%h lat=%0d want %h",
                         k, as[k], bs[k], p, lat, want[k]);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] p;
        int          lat;
        sel = 2;
        wait_ready();
        tb_pready = 1'b0;
        run_op(1'b0, 8'd3, 8'd4, p, lat);
        n_checks++;
        if (p !== 16'd12 || lat !== ref_latency(2, 1'b0, 8'd4)) begin
            n_errors++;
            $display("FAIL bp_first: product=%0d lat=%0d want 12 lat %0d",
                     p, lat, ref_latency(2, 1'b0, 8'd4));
        end
        tb_valid = 1'b1;
        tb_mode  = 1'b1;
        tb_a     = 8'hAA;
        tb_b     = 8'h55;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs_pv !== 1'b1 || obs_ready !== 1'b0 || obs_prod !== 16'd12) begin
                n_errors++;
                $display("FAIL bp_hold_%0d: valid=%b ready=%b product=%0d want 1/0/12",
                         i, obs_pv, obs_ready, obs_prod);
            end
        end
        tb_valid  = 1'b0;
        tb_pready = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (obs_pv !== 1'b0 || obs_ready !== 1'b1 || obs_prod !== 16'd12) begin
            n_errors++;
            $display("FAIL bp_release: valid=%b ready=%b product=%0d want 0/1/12",
                     obs_pv, obs_ready, obs_prod);
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] p;
        int          lat;
        sel = 2;
        wait_ready();
        tb_mode  = 1'b0;
        tb_a     = 8'd9;
        tb_b     = 8'd9;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        tb_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (obs_ready !== 1'b1 || obs_pv !== 1'b0 || obs_prod !== 16'h0) begin
            n_errors++;
            $display("FAIL mid_reset: ready=%b valid=%b product=%h want 1/0/0000",
                     obs_ready, obs_pv, obs_prod);
        end
        #2;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            n_checks++;
            if (obs_pv !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_reset_abort_%0d: valid=%b want 0", i, obs_pv);
            end
        end
        run_op(1'b0, 8'd15, 8'd17, p, lat);
        n_checks++;
        if (p !== 16'd255 || lat !== ref_latency(2, 1'b0, 8'd17)) begin
            n_errors++;
            $display("FAIL post_reset_15x17: product=%0d lat=%0d want 255 lat %0d",
                     p, lat, ref_latency(2, 1'b0, 8'd17));
        end
    endtask

    task automatic test_early_term();
        logic [15:0] p;
        int          lat;
        sel = 1;
        run_op(1'b0, 8'h55, 8'h03, p, lat);
        n_checks++;
        if (p !== 16'h00FF || lat !== ref_latency(1, 1'b0, 8'h03)) begin
            n_errors++;
            $display("FAIL early_55x03: product=%h lat=%0d want 00ff lat %0d",
                     p, lat, ref_latency(1, 1'b0, 8'h03));
        end
        run_op(1'b0, 8'h55, 8'h00, p, lat);
        n_checks++;
        if (p !== 16'h0000 || lat !== ref_latency(1, 1'b0, 8'h00)) begin
            n_errors++;
            $display("FAIL early_55x00: product=%h lat=%0d want 0000 lat %0d",
                     p, lat, ref_latency(1, 1'b0, 8'h00));
        end
    endtask

    task automatic test_back_to_back();
        int hits[$];
        int l;
        sel = 2;
        l = ref_latency(2, 1'b0, 8'd7);
        wait_ready();
        tb_mode  = 1'b0;
        tb_a     = 8'd6;
        tb_b     = 8'd7;
        tb_valid = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 1; i <= 40 && hits.size() < 2; i++) begin
            @(posedge clk);
            #1;
            if (obs_pv) begin
                hits.push_back(i);
                n_checks++;
                if (obs_prod !== 16'd42) begin
                    n_errors++;
                    $display("FAIL b2b_product: got %0d want 42", obs_prod);
                end
            end
        end
        tb_valid = 1'b0;
        n_checks++;
        if (hits.size() != 2 || hits[0] != l || hits[1] != 2 * l + 2) begin
            n_errors++;
            $display("FAIL b2b_timing: %0d results, first=%0d second=%0d want %0d and %0d",
                     hits.size(), (hits.size() > 0) ? hits[0] : -1,
                     (hits.size() > 1) ? hits[1] : -1, l, 2 * l + 2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_sweep();
        logic [7:0]  corners[5];
        int          radices[3];
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic [15:0] want;
        int          lat;
        int          wl;
        corners = '{8'h00, 8'h01, 8'hFF, 8'h80, 8'h7F};
        radices = '{1, 2, 4};
        tb_pready = 1'b1;
        for (int r = 0; r < 3; r++) begin
            sel = radices[r];
            for (int m = 0; m < 2; m++) begin
                for (int i = 0; i < 1000; i++) begin
                    if (i < 25) begin
                        a = corners[i / 5];
                        b = corners[i % 5];
                    end else begin
                        a = 8'($urandom);
                        b = 8'($urandom);
                    end
                    run_op(m[0], a, b, p, lat);
                    want = ref_product(m[0], a, b);
                    wl   = ref_latency(sel, m[0], b);
                    n_checks++;
                    if (p !== want) begin
                        n_errors++;
                        $display("FAIL sweep_product r%0d s%0d: %h*%h got %h want %h",
                                 sel, m, a, b, p, want);
                    end
                    n_checks++;
                    if (lat != wl) begin
                        n_errors++;
                        $display("FAIL sweep_latency r%0d s%0d: b=%h got %0d want %0d",
                                 sel, m, b, lat, wl);
                    end
                end
            end
        end
    endtask

    initial begin
        sel = 2;
        test_reset();
        test_unsigned_basic();
        test_signed();
        test_backpressure();
        test_reset_mid();
        test_early_term();
        test_back_to_back();
        test_sweep();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached after %0d checks", n_checks);
        $fatal(1, "watchdog");
    end

endmodule
